// File: rtl/fft_pkg.sv
// Shared constants, sample type and bit-reverse helper for the FFT magnitude stage.
package fft_pkg;

   localparam int NSAMPLES_DEF = 1024;
   localparam int WIN_DEF      = 16;
   localparam int W_DEF        = 16;
   localparam int SHIFT_DEF    = 15;
   localparam int MAX_NB       = 16;

   typedef struct packed {
      logic signed [WIN_DEF-1:0] re;
      logic signed [WIN_DEF-1:0] im;
   } cplx_t;

   // Reverses the low nb bits of x; bits at and above nb come back as zero.
   function automatic logic [MAX_NB-1:0] bit_reverse(input logic [MAX_NB-1:0] x, input int nb);
      logic [MAX_NB-1:0] r;
      r = '0;
      for (int k = 0; k < MAX_NB; k++) begin
         if (k < nb) r[k] = x[nb-1-k];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_mag_peak.sv
// Running-max tracker over the positive-frequency half of each frame (DC excluded).
module fft_mag_peak #(
   parameter int W     = 16,
   parameter int NBits = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [W-1:0]     mag,
   input  logic             valid,
   input  logic [NBits-1:0] bin_idx,
   input  logic             i_lsb,
   input  logic             frame_done,
   input  logic             gap_clear,
   output logic [W-1:0]     peak_mag,
   output logic [NBits-1:0] peak_bin
);

   logic [W-1:0]     run_max;
   logic [NBits-1:0] run_bin;
   logic             cand;
   logic             take;

   // Even arrival index means natural bin < NSamples/2; strict compare keeps the earliest tie.
   assign cand = valid && !i_lsb && (bin_idx != '0);
   assign take = cand && (mag > run_max);

   always_ff @(posedge clk) begin
      if (reset) begin
         run_max  <= '0;
         run_bin  <= '0;
         peak_mag <= '0;
         peak_bin <= '0;
      end else if (frame_done) begin
         peak_mag <= take ? mag : run_max;
         peak_bin <= take ? bin_idx : run_bin;
         run_max  <= '0;
         run_bin  <= '0;
      end else if (gap_clear) begin
         run_max <= '0;
         run_bin <= '0;
      end else if (take) begin
         run_max <= mag;
         run_bin <= bin_idx;
      end
   end

endmodule

// File: rtl/fft_mag_calc.sv
// Pipelined complex-to-magnitude stage with bin tracking and frame-done flag.
// Optional spectral peak tracking is enabled by defining PEAK_TRACK_EN.
module fft_mag_calc
   import fft_pkg::*;
#(
   parameter int  NSamples = NSAMPLES_DEF,
   parameter int  WIn      = WIN_DEF,
   parameter int  W        = W_DEF,
   parameter int  Shift    = SHIFT_DEF,
   localparam int NBits    = $clog2(NSamples)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic signed [WIn-1:0] re,
   input  logic signed [WIn-1:0] im,
   input  logic                  in_valid,
   output logic [W-1:0]          mag,
   output logic                  mag_valid,
   output logic [NBits-1:0]      bin_idx,
   output logic                  frame_done,
   output logic [W-1:0]          peak_mag,
   output logic [NBits-1:0]      peak_bin
);

   localparam int               STAGES  = 3;
   localparam int               PW      = 2*WIn;
   localparam logic [PW:0]      SAT_LIM = (PW+1)'({W{1'b1}});
   localparam logic [NBits-1:0] LAST    = NBits'(NSamples-1);

   logic [STAGES:1]       vld_pipe;
   logic signed [WIn-1:0] s1_re, s1_im;
   logic signed [PW-1:0]  re_x, im_x;
   logic [PW-1:0]         s2_re_sq, s2_im_sq;
   logic [PW:0]           sum, sum_sh;
   logic [W-1:0]          mag_nxt;
   logic [NBits-1:0]      cnt;

   always_ff @(posedge clk) begin
      if (reset) vld_pipe <= '0;
      else       vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
   end

   assign mag_valid = vld_pipe[STAGES];

   // S1: capture the bin
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_re <= '0;
         s1_im <= '0;
      end else begin
         s1_re <= re;
         s1_im <= im;
      end
   end

   // S2: squares are non-negative and fit in 2*WIn bits, even for the most negative input
   assign re_x = PW'(s1_re);
   assign im_x = PW'(s1_im);

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_re_sq <= '0;
         s2_im_sq <= '0;
      end else begin
         s2_re_sq <= re_x * re_x;
         s2_im_sq <= im_x * im_x;
      end
   end

   // S3: widen, scale, saturate
   assign sum     = {1'b0, s2_re_sq} + {1'b0, s2_im_sq};
   assign sum_sh  = sum >> Shift;
   assign mag_nxt = (sum_sh > SAT_LIM) ? {W{1'b1}} : sum_sh[W-1:0];

   // Arrival counter follows the S3 valid bit; any hole restarts the frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         mag        <= '0;
         bin_idx    <= '0;
         frame_done <= 1'b0;
         cnt        <= '0;
      end else begin
         mag        <= mag_nxt;
         frame_done <= vld_pipe[2] && (cnt == LAST);
         if (vld_pipe[2]) begin
            bin_idx <= NBits'(bit_reverse(MAX_NB'(cnt), NBits));
            cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end

`ifdef PEAK_TRACK_EN
   logic i_lsb;

   always_ff @(posedge clk) begin
      if (reset)            i_lsb <= 1'b0;
      else if (vld_pipe[2]) i_lsb <= cnt[0];
   end

   fft_mag_peak #(
      .W     (W),
      .NBits (NBits)
   ) u_peak (
      .clk        (clk),
      .reset      (reset),
      .mag        (mag),
      .valid      (mag_valid),
      .bin_idx    (bin_idx),
      .i_lsb      (i_lsb),
      .frame_done (frame_done),
      .gap_clear  (~mag_valid),
      .peak_mag   (peak_mag),
      .peak_bin   (peak_bin)
   );
`else
   assign peak_mag = '0;
   assign peak_bin = '0;
`endif

endmodule

// File: tb/tb_fft_mag_calc.sv
// Bench for fft_mag_calc: default-scaled and unscaled instances checked against an arithmetic model.
module tb_fft_mag_calc;
   import fft_pkg::*;

   localparam int N    = 1024;
   localparam int NB   = 10;
   localparam int MAXC = 16384;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic signed [15:0]      re = '0, im = '0;
   logic                    in_valid = 1'b0;
   logic [1:0][15:0]        mag_o, pk_mag_o;
   logic [1:0]              mv_o, fd_o;
   logic [1:0][NB-1:0]      bin_o, pk_bin_o;

   always #5 clk = ~clk;

   fft_mag_calc dut (
      .clk(clk), .reset(reset), .re(re), .im(im), .in_valid(in_valid),
      .mag(mag_o[0]), .mag_valid(mv_o[0]), .bin_idx(bin_o[0]), .frame_done(fd_o[0]),
      .peak_mag(pk_mag_o[0]), .peak_bin(pk_bin_o[0])
   );

   fft_mag_calc #(.Shift(0)) dut0 (
      .clk(clk), .reset(reset), .re(re), .im(im), .in_valid(in_valid),
      .mag(mag_o[1]), .mag_valid(mv_o[1]), .bin_idx(bin_o[1]), .frame_done(fd_o[1]),
      .peak_mag(pk_mag_o[1]), .peak_bin(pk_bin_o[1])
   );

   int pass_cnt = 0, tot_cnt = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      tot_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int exp_mag(input int r, input int i, input int sh);
      longint s;
      s = (longint'(r) * r + longint'(i) * i) >> sh;
      return (s > 65535) ? 65535 : int'(s);
   endfunction

   function automatic int rev(input int x);
      int r = 0;
      for (int k = 0; k < NB; k++) if (((x >> k) & 1) != 0) r |= 1 << (NB-1-k);
      return r;
   endfunction

   // Input history as sampled by the DUT on each rising edge
   bit h_v[MAXC], h_rst[MAXC];
   int h_re[MAXC], h_im[MAXC];
   int cyc = 0;

   always @(posedge clk) begin
      if (cyc < MAXC) begin
         h_v[cyc] = in_valid; h_rst[cyc] = reset; h_re[cyc] = re; h_im[cyc] = im;
      end
      cyc++;
   end

   // Model: output after edge e reflects the input of edge e-2 unless a reset intervened.
   int  pos = 0;
   int  fm[2][N];
   bit  pend[2];
   int  pend_mag[2], pend_bin[2], e_pk_mag[2], e_pk_bin[2];
   int  dut_fd_cnt = 0;
   int  fd_cyc[$];

   always @(negedge clk) begin
      int e, em, best, bb, n;
      bit ev, efd;
      if (cyc >= 1 && cyc < MAXC) begin
         e  = cyc - 1;
         ev = (e >= 2) && h_v[e-2] && !h_rst[e-2] && !h_rst[e-1] && !h_rst[e];
         for (int d = 0; d < 2; d++) begin
            if (h_rst[e]) begin
               pend[d] = 0; e_pk_mag[d] = 0; e_pk_bin[d] = 0;
            end else if (pend[d]) begin
               e_pk_mag[d] = pend_mag[d]; e_pk_bin[d] = pend_bin[d]; pend[d] = 0;
            end
`ifdef PEAK_TRACK_EN
            chk($sformatf("peak_mag%0d", d), pk_mag_o[d], e_pk_mag[d]);
            chk($sformatf("peak_bin%0d", d), pk_bin_o[d], e_pk_bin[d]);
`else
            chk($sformatf("peak_mag%0d", d), pk_mag_o[d], 0);
            chk($sformatf("peak_bin%0d", d), pk_bin_o[d], 0);
`endif
            chk($sformatf("mag_valid%0d", d), mv_o[d], ev);
            if (h_rst[e]) begin
               chk($sformatf("rst_mag%0d", d), mag_o[d], 0);
               chk($sformatf("rst_bin%0d", d), bin_o[d], 0);
               chk($sformatf("rst_fd%0d", d), fd_o[d], 0);
            end else if (ev) begin
               em  = exp_mag(h_re[e-2], h_im[e-2], (d == 0) ? 15 : 0);
               efd = (pos == N-1);
               chk($sformatf("mag%0d", d), mag_o[d], em);
               chk($sformatf("bin_idx%0d", d), bin_o[d], rev(pos));
               chk($sformatf("frame_done%0d", d), fd_o[d], efd);
               fm[d][pos] = em;
               if (efd) begin
                  best = 0; bb = 0;
                  for (int p = 0; p < N; p++) begin
                     n = rev(p);
                     if (n >= 1 && n < N/2 && fm[d][p] > best) begin best = fm[d][p]; bb = n; end
                  end
                  pend[d] = 1; pend_mag[d] = best; pend_bin[d] = bb;
               end
            end else begin
               chk($sformatf("idle_fd%0d", d), fd_o[d], 0);
            end
         end
         if (fd_o[1]) begin dut_fd_cnt++; fd_cyc.push_back(cyc); end
         if (h_rst[e] || !ev) pos = 0;
         else pos = (pos == N-1) ? 0 : pos + 1;
      end
   end

   // Inputs change 1 time unit after a rising edge and are sampled at the next one.
   task automatic step(input bit v, input int r, input int i);
      in_valid = v; re = 16'(r); im = 16'(i);
      @(posedge clk); #1;
   endtask

   task automatic flush();
      for (int k = 0; k < 4; k++) step(0, 0, 0);
   endtask

   task automatic one(input int r, input int i, input int exp15, input int exp0);
      step(1, r, i); step(0, 0, 0); step(0, 0, 0);
      chk("one_valid", mv_o[1], 1);
      chk("one_mag_shift15", mag_o[0], exp15);
      chk("one_mag_shift0", mag_o[1], exp0);
   endtask

   task automatic stream(input int n, input int seed);
      for (int p = 0; p < n; p++)
         step(1, ((p + seed) * 7919) % 65536 - 32768, ((p + seed) * 104729) % 65536 - 32768);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      cplx_t s;
      chk("model_rev1", rev(1), 512);
      chk("model_rev3", rev(3), 768);
      chk("model_mag", exp_mag(3, 4, 0), 25);

      reset = 1'b1;
      @(posedge clk); #1;
      step(0, 0, 0); step(0, 0, 0);
      chk("reset_mag", mag_o[0], 0);
      chk("reset_valid", mv_o[0], 0);
      chk("reset_fd", fd_o[0], 0);
      reset = 1'b0;
      step(0, 0, 0);

      one(3, 4, 0, 25);
      one(-32768, 0, 32768, 65535);
      one(-32768, -32768, 65535, 65535);
      one(16384, 16384, 16384, 65535);
      flush();

      // Two back-to-back frames
      base = dut_fd_cnt;
      stream(2*N, 1);
      flush();
      chk("two_frames_fd", dut_fd_cnt - base, 2);
      if (fd_cyc.size() >= 2) chk("frame_spacing", fd_cyc[fd_cyc.size()-1] - fd_cyc[fd_cyc.size()-2], N);
      else chk("frame_spacing_count", fd_cyc.size(), 2);

      // Gap after 100 samples restarts the frame
      base = dut_fd_cnt;
      stream(100, 7);
      step(0, 0, 0);
      stream(N, 9);
      flush();
      chk("gap_fd", dut_fd_cnt - base, 1);

      // Reset mid-frame
      base = dut_fd_cnt;
      stream(500, 3);
      reset = 1'b1;
      step(1, 100, 100);
      reset = 1'b0;
      chk("midreset_valid", mv_o[1], 0);
      stream(N, 5);
      flush();
      chk("midreset_fd", dut_fd_cnt - base, 1);

      // Tone at bin 37 against larger DC and negative-frequency bins
      base = dut_fd_cnt;
      for (int p = 0; p < N; p++) begin
         case (rev(p))
            0:       s = '{re: 16'sd70, im: 16'sd10};
            37:      s = '{re: 16'sd30, im: 16'sd10};
            600:     s = '{re: 16'sd90, im: 16'sd30};
            default: s = '{re: 16'sd0,  im: 16'sd0};
         endcase
         step(1, s.re, s.im);
      end
      flush();
      chk("peak_frame_fd", dut_fd_cnt - base, 1);
`ifdef PEAK_TRACK_EN
      chk("peak_mag_lit", pk_mag_o[1], 1000);
      chk("peak_bin_lit", pk_bin_o[1], 37);
`else
      chk("peak_mag_lit", pk_mag_o[1], 0);
      chk("peak_bin_lit", pk_bin_o[1], 0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/fft_mag_calc.md
Name: fft_mag_calc

Overview:
- Pipelined complex-to-magnitude stage between the FFT core and the FFT output buffer.
- Accepts one complex bin per cycle in the FFT's bit-reversed output order.
- Computes a scaled, saturated squared magnitude and emits it as a contiguous `mag`/`mag_valid` stream.
- Tracks the bin position within each frame and flags frame completion; optionally tracks the spectral peak.

Parameters:
- NSamples, 1024, FFT length in bins per frame; power of two, >= 4.
- WIn, 16, signed width of each of `re` and `im`.
- W, 16, unsigned output magnitude width.
- Shift, 15, right-shift applied to `re^2+im^2` before saturation to W bits.
- NBits, $clog2(NSamples), bin index width (derived, not overridden).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- re  in  WIn  signed real part of FFT bin
- im  in  WIn  signed imaginary part of FFT bin
- in_valid  in  1  re/im valid this cycle; asserted contiguously for NSamples cycles per frame
- mag  out  W  scaled squared magnitude
- mag_valid  out  1  mag valid this cycle
- bin_idx  out  NBits  natural-order bin index of current mag (bit-reversed arrival counter)
- frame_done  out  1  one-cycle pulse coincident with the last mag of a complete frame
- peak_mag  out  W  largest positive-frequency mag of last complete frame (PEAK_TRACK_EN)
- peak_bin  out  NBits  natural bin index of peak_mag (PEAK_TRACK_EN)

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on `reset`.
- On reset, all outputs are 0: mag, mag_valid, bin_idx, frame_done, peak_mag, peak_bin. All pipeline valid bits and the arrival counter are also cleared.
- Reset mid-frame discards every in-flight sample; no frame_done is produced for that frame.
- Pipeline is 3 stages, fixed latency 3: the input at cycle t appears as mag/mag_valid at t+3. There is no backpressure.
  - S1: register re, im, in_valid.
  - S2: re*re and im*im, each unsigned 2*WIn bits.
  - S3: sum in 2*WIn+1 bits, logical shift right by Shift; if the result >= 2^W, mag = 2^W-1, else the low W bits.
- Arrival counter i (NBits wide) advances on every S3-valid cycle; bin_idx = bit-reverse(i).
  - When i == NSamples-1 with valid: frame_done=1 and i wraps to 0.
  - A valid gap mid-frame (S3 valid low while i != 0) resets i to 0 and produces no frame_done. This matches the downstream buffer, which restarts on any valid drop.
  - Back-to-back frames with no gap are legal; i wraps and continues.
- mag_valid is the S3 valid bit exactly; holes in in_valid propagate unchanged.
- frame_done is never asserted when mag_valid is 0.

Optional Feature:
- Macro PEAK_TRACK_EN.
- When defined:
  - Running max is evaluated only over bins with i[0]==0 (natural index < NSamples/2), excluding DC (bin_idx == 0).
  - Strict greater-than compare, so on a tie the earliest-arriving bin wins.
  - On frame_done, peak_mag/peak_bin update to the frame result; the running max clears for the next frame.
  - A gap or reset clears the running max; peak outputs keep the last complete frame's values (reset clears them to 0).
  - The update is visible the cycle after frame_done.
- When undefined: peak_mag and peak_bin are constant 0 and no tracking logic is synthesised.

Decomposition:
- Package fft_pkg: default NSamples, WIn, W constants; a bit_reverse function parameterised on NBits; typedef for the signed complex sample struct {re, im}.
- One sub-module, fft_mag_peak: running-max tracker with inputs mag, valid, bin_idx, i[0], frame_done, gap_clear. Instantiated only under PEAK_TRACK_EN.

Test Plan:
- Latency/arithmetic (Shift=0): re=3, im=4 at cycle 0 -> mag=25, mag_valid=1 at cycle 3. re=-32768, im=0 -> mag saturates to 65535.
- Scaling (defaults): re=im=-32768 -> sum 2^31, >>15 = 65536 -> mag=65535. re=im=16384 -> mag=16384.
- Full frame: 1024 contiguous valid inputs -> 1024 contiguous mag_valid, bin_idx sequence 0,512,256,768,..., frame_done only on the 1024th output. Back-to-back second frame -> second frame_done exactly 1024 cycles later.
- Gap: drop in_valid for 1 cycle after 100 samples, then 1024 contiguous -> no frame_done at sample 100; bin_idx restarts at 0; exactly one frame_done at the end.
- Reset mid-frame: reset at sample 500 for 1 cycle -> mag_valid low from the next cycle, no frame_done, bin_idx restarts at 0 with the next input.
- PEAK_TRACK_EN: tone at natural bin 37 (mag 1000), DC=5000, bin 600=9000 -> peak_mag=1000, peak_bin=37 the cycle after frame_done. Macro undefined -> both remain 0.
